// File: rtl/pim_dma_pkg.sv
// Shared definitions for the PIM DMA: command codes, FSM states, status codes
// and the default PIM register map.
package pim_dma_pkg;

   localparam logic [2:0] F3_WEIGHT = 3'b001;
   localparam logic [2:0] F3_ACT    = 3'b010;
   localparam logic [2:0] F3_LOAD   = 3'b100;
   localparam logic [2:0] F3_KEY    = 3'b101;
   localparam logic [2:0] F3_VREF   = 3'b110;
   localparam logic [2:0] F3_MODE   = 3'b111;

   localparam logic [31:0] PIM_CTRL_DEF     = 32'h4000_0010;
   localparam logic [31:0] PIM_R_DEF        = 32'h4000_0020;
   localparam logic [31:0] PIM_W_WEIGHT_DEF = 32'h4000_0040;
   localparam logic [31:0] PIM_W_ACT_DEF    = 32'h4000_0080;
   localparam logic [31:0] PIM_W_KEY_DEF    = 32'h4000_0100;
   localparam logic [31:0] PIM_W_VREF_DEF   = 32'h4000_0200;
   localparam logic [31:0] PIM_W_MODE_DEF   = 32'h4000_0400;

   typedef enum logic [1:0] {
      S_IDLE,
      S_POLL,
      S_STREAM,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_BAD     = 2'b01,
      ST_TIMEOUT = 2'b10,
      ST_ABORT   = 2'b11
   } status_t;

   function automatic logic funct3_valid(input logic [2:0] f3);
      return (f3 != 3'b000) && (f3 != 3'b011);
   endfunction

endpackage

// File: rtl/pim_dma_xfer_ctr.sv
// Word counters plus the read-data staging buffer of the stream path; a skid
// entry keeps a read that lands during a grant gap from overwriting buf_data.
module pim_dma_xfer_ctr #(
   parameter int SIZE_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              load,
   input  logic [SIZE_W-1:0] size,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic [SIZE_W-1:0] rd_left,
   output logic [SIZE_W-1:0] wr_left,
   output logic [DATA_W-1:0] buf_data,
   output logic              buf_valid
);

   logic              rd_pend;
   logic [DATA_W-1:0] skid_data;
   logic              skid_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_left    <= '0;
         wr_left    <= '0;
         rd_pend    <= 1'b0;
         buf_data   <= '0;
         buf_valid  <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
      end else if (load) begin
         rd_left    <= size;
         wr_left    <= size;
         rd_pend    <= 1'b0;
         buf_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         rd_pend <= rd_en;
         if (rd_en) rd_left <= rd_left - 1'b1;
         if (wr_en) wr_left <= wr_left - 1'b1;
         // Data arrives the cycle after a read strobe whether or not the bus is still granted
         if (wr_en) begin
            if (skid_valid) begin
               buf_data   <= skid_data;
               skid_valid <= rd_pend;
               if (rd_pend) skid_data <= rd_data;
            end else if (rd_pend) begin
               buf_data <= rd_data;
            end else begin
               buf_valid <= 1'b0;
            end
         end else if (rd_pend) begin
            if (!buf_valid) begin
               buf_data  <= rd_data;
               buf_valid <= 1'b1;
            end else begin
               skid_data  <= rd_data;
               skid_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pim_dma_v2.sv
// DMA between the SRAM port (0) and PIM register space (port 1): polls the PIM
// control register, then streams one word per granted cycle.
module pim_dma_v2
   import pim_dma_pkg::*;
#(
   parameter int          ADDR_W       = 32,
   parameter int          DATA_W       = 32,
   parameter int          SIZE_W       = 14,
   parameter int          NUM_PIM      = 4,
   parameter int unsigned POLL_TIMEOUT = 1024,
   parameter logic [ADDR_W-1:0] PIM_CTRL     = ADDR_W'(PIM_CTRL_DEF),
   parameter logic [ADDR_W-1:0] PIM_R        = ADDR_W'(PIM_R_DEF),
   parameter logic [ADDR_W-1:0] PIM_W_WEIGHT = ADDR_W'(PIM_W_WEIGHT_DEF),
   parameter logic [ADDR_W-1:0] PIM_W_ACT    = ADDR_W'(PIM_W_ACT_DEF),
   parameter logic [ADDR_W-1:0] PIM_W_KEY    = ADDR_W'(PIM_W_KEY_DEF),
   parameter logic [ADDR_W-1:0] PIM_W_VREF   = ADDR_W'(PIM_W_VREF_DEF),
   parameter logic [ADDR_W-1:0] PIM_W_MODE   = ADDR_W'(PIM_W_MODE_DEF),
   localparam int BE_W  = DATA_W / 8,
   localparam int SEL_W = $clog2(NUM_PIM)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [2:0]        i_cmd_funct3,
   input  logic [SEL_W-1:0]  i_cmd_sel,
   input  logic [SIZE_W-1:0] i_cmd_size,
   input  logic [ADDR_W-1:0] i_cmd_mem_addr,
   input  logic [ADDR_W-1:0] i_cmd_stride,
   input  logic              i_abort,
   output logic              o_bus_req,
   input  logic              i_bus_gnt,
   output logic [ADDR_W-1:0] o_addr_0,
   output logic              o_write_0,
   output logic              o_read_0,
   output logic [BE_W-1:0]   o_be_0,
   output logic [DATA_W-1:0] o_wr_data_0,
   input  logic [DATA_W-1:0] i_rd_data_0,
   output logic [ADDR_W-1:0] o_addr_1,
   output logic              o_write_1,
   output logic              o_read_1,
   output logic [BE_W-1:0]   o_be_1,
   output logic [DATA_W-1:0] o_wr_data_1,
   input  logic [DATA_W-1:0] i_rd_data_1,
   output logic              o_busy,
   output logic              o_done,
   output logic [1:0]        o_status
);

   state_t            state;
   status_t           status;
   logic              op_load;
   logic [ADDR_W-1:0] pim_addr;
   logic [ADDR_W-1:0] mem_ptr;
   logic [ADDR_W-1:0] stride;
   logic              poll_pend;
   logic [31:0]       poll_cnt;
   logic [ADDR_W-1:0] cmd_base;
   logic              accept;
   logic              poll_rd;
   logic              rd_en;
   logic              wr_en;
   logic              ctrl_ready;
   logic [SIZE_W-1:0] rd_left;
   logic [SIZE_W-1:0] wr_left;
   logic [DATA_W-1:0] buf_data;
   logic              buf_valid;

   assign accept      = i_cmd_valid && (state == S_IDLE);
   assign poll_rd     = (state == S_POLL) && i_bus_gnt && !i_abort;
   assign rd_en       = (state == S_STREAM) && i_bus_gnt && !i_abort && (rd_left != '0);
   assign wr_en       = (state == S_STREAM) && i_bus_gnt && !i_abort && buf_valid;
   assign ctrl_ready  = op_load ? (i_rd_data_1[1:0] == 2'b11) : i_rd_data_1[0];
   assign o_cmd_ready = (state == S_IDLE);
   assign o_busy      = (state != S_IDLE);
   assign o_done      = (state == S_DONE);
   assign o_bus_req   = (state == S_POLL) || (state == S_STREAM);
   assign o_status    = status;

   always_comb begin
      case (i_cmd_funct3)
         F3_ACT:  cmd_base = PIM_W_ACT;
         F3_LOAD: cmd_base = PIM_R;
         F3_KEY:  cmd_base = PIM_W_KEY;
         F3_VREF: cmd_base = PIM_W_VREF;
         F3_MODE: cmd_base = PIM_W_MODE;
         default: cmd_base = PIM_W_WEIGHT;
      endcase
   end

   pim_dma_xfer_ctr #(
      .SIZE_W (SIZE_W),
      .DATA_W (DATA_W)
   ) u_xfer_ctr (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .load      (accept),
      .size      (i_cmd_size),
      .rd_en     (rd_en),
      .wr_en     (wr_en),
      .rd_data   (op_load ? i_rd_data_1 : i_rd_data_0),
      .rd_left   (rd_left),
      .wr_left   (wr_left),
      .buf_data  (buf_data),
      .buf_valid (buf_valid)
   );

   // Load moves PIM -> SRAM; every other op moves SRAM -> PIM
   always_comb begin
      o_addr_0    = '0;
      o_write_0   = 1'b0;
      o_read_0    = 1'b0;
      o_be_0      = '0;
      o_wr_data_0 = '0;
      o_addr_1    = '0;
      o_write_1   = 1'b0;
      o_read_1    = 1'b0;
      o_be_1      = '0;
      o_wr_data_1 = '0;
      if (poll_rd) begin
         o_addr_1 = PIM_CTRL;
         o_read_1 = 1'b1;
         o_be_1   = '1;
      end
      if (rd_en) begin
         if (op_load) begin
            o_addr_1 = pim_addr;
            o_read_1 = 1'b1;
            o_be_1   = '1;
         end else begin
            o_addr_0 = mem_ptr;
            o_read_0 = 1'b1;
            o_be_0   = '1;
         end
      end
      if (wr_en) begin
         if (op_load) begin
            o_addr_0    = mem_ptr;
            o_write_0   = 1'b1;
            o_be_0      = '1;
            o_wr_data_0 = buf_data;
         end else begin
            o_addr_1    = pim_addr;
            o_write_1   = 1'b1;
            o_be_1      = '1;
            o_wr_data_1 = buf_data;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= S_IDLE;
         status    <= ST_OK;
         op_load   <= 1'b0;
         pim_addr  <= '0;
         mem_ptr   <= '0;
         stride    <= '0;
         poll_pend <= 1'b0;
         poll_cnt  <= '0;
      end else begin
         poll_pend <= poll_rd;
         case (state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  op_load  <= (i_cmd_funct3 == F3_LOAD);
                  pim_addr <= cmd_base + ADDR_W'({i_cmd_sel, 2'b00});
                  mem_ptr  <= i_cmd_mem_addr;
                  stride   <= i_cmd_stride;
                  poll_cnt <= '0;
                  if (!funct3_valid(i_cmd_funct3) || (i_cmd_size == '0)) begin
                     state  <= S_DONE;
                     status <= ST_BAD;
                  end else begin
                     state <= S_POLL;
                  end
               end
            end
            S_POLL: begin
               if (i_abort) begin
                  state  <= S_DONE;
                  status <= ST_ABORT;
               end else if (poll_pend && ctrl_ready) begin
                  state <= S_STREAM;
               end else if (poll_pend) begin
                  poll_cnt <= poll_cnt + 1'b1;
                  if ((POLL_TIMEOUT != 0) && (poll_cnt == POLL_TIMEOUT - 1)) begin
                     state  <= S_DONE;
                     status <= ST_TIMEOUT;
                  end
               end
            end
            S_STREAM: begin
               if (op_load ? wr_en : rd_en) mem_ptr <= mem_ptr + stride;
               if (i_abort) begin
                  state  <= S_DONE;
                  status <= ST_ABORT;
               end else if (wr_en && (wr_left == SIZE_W'(1))) begin
                  state  <= S_DONE;
                  status <= ST_OK;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/pim_dma_v2.md
# pim_dma_v2

Parametrised successor DMA that moves word streams between the system SRAM port (port 0) and the PIM macro register space (port 1) under bus arbitration. Adds a valid/ready command handshake, configurable SRAM stride, a poll timeout, abort, and a done/status report. The read-to-write path is fully pipelined, sustaining one word per granted cycle across grant loss.

## Interface
- ADDR_W, 32, address width of both ports
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8
- SIZE_W, 14, word-count width; max transfer 2^SIZE_W-1 words
- NUM_PIM, 4, number of PIM macros; sel width SEL_W = $clog2(NUM_PIM)
- POLL_TIMEOUT, 1024, granted poll cycles before timeout; 0 disables timeout
- PIM_CTRL / PIM_R / PIM_W_WEIGHT / PIM_W_ACT / PIM_W_KEY / PIM_W_VREF / PIM_W_MODE, 32'h4000_0010 / _0020 / _0040 / _0080 / _0100 / _0200 / _0400, PIM register bases
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_funct3  in  3  001 weight, 010 activation, 100 load, 101 key, 110 vref, 111 mode
- i_cmd_sel  in  SEL_W  target macro
- i_cmd_size  in  SIZE_W  word count
- i_cmd_mem_addr  in  ADDR_W  SRAM start byte address
- i_cmd_stride  in  ADDR_W  SRAM byte step per word
- i_abort  in  1  cancel active command
- o_bus_req / i_bus_gnt  out/in  1  bus request / grant
- o_addr_0, o_write_0, o_read_0, o_be_0, o_wr_data_0, i_rd_data_0  SRAM port (ADDR_W,1,1,BE_W,DATA_W,DATA_W)
- o_addr_1, o_write_1, o_read_1, o_be_1, o_wr_data_1, i_rd_data_1  PIM port, same widths
- o_busy  out  1  not IDLE
- o_done  out  1  one-cycle completion pulse
- o_status  out  2  00 ok, 01 bad command, 10 poll timeout, 11 aborted; held until next done

## Operation
- Accept on i_cmd_valid && o_cmd_ready; all fields registered. funct3 000/011 or size 0 -> DONE, status 01.
- PIM data address = op base + {sel,2'b00}; load uses PIM_R, others their write base.
- Direction: load = PIM -> SRAM; all other ops = SRAM -> PIM. SRAM address starts at mem_addr, += stride per issued read (write dir) or issued write (load); wraps mod 2^ADDR_W.
- States: IDLE -> POLL (accept) -> STREAM (ready seen) -> DONE -> IDLE.
- POLL: req=1; each granted cycle read PIM_CTRL (be all ones). Ready = rd_data_1[0] for writes, [0]&&[1] for load, sampled the cycle after a CTRL read. Timeout counter increments on granted not-ready samples; reaching POLL_TIMEOUT -> DONE, status 10.
- STREAM: rd_left, wr_left load size. Granted cycle: if rd_left>0 issue source read, rd_left--; if buf_valid issue destination write of buf, wr_left--. Read data captured into buf the cycle after any read strobe, independent of grant. Ungranted cycle: all strobes/addresses 0, counters hold. wr_left reaching 0 -> DONE, status 00.
- i_abort in POLL/STREAM: strobes 0 that cycle, next DONE, status 11; abort wins over any same-cycle completion. Ignored in IDLE/DONE.
- DONE: o_done=1, o_busy=1, req=0, one cycle.

## Timing
- Reset: state IDLE, o_cmd_ready=1, every other output 0, o_status 00.
- Uninterrupted grant: first read in first granted STREAM cycle, first write 2 cycles later; STREAM lasts size+2 cycles.
- o_cmd_ready reasserts the cycle after DONE; back-to-back commands have 1 idle cycle.
- Reset mid-transfer: immediate return to IDLE, counters cleared, no further strobes.

## Structure
- Package pim_dma_pkg: funct3 codes, state enum, status codes, default base addresses.
- Sub-module pim_dma_xfer_ctr: rd_left/wr_left down-counters, buf and buf_valid; FSM and address generation stay in top.

## Test plan
- Weight, sel=2, size=4, addr 0x100, stride 4, constant grant, ready at once -> PIM writes to 0x4000_0048 of SRAM words 0x100..0x10C, done after 6 STREAM cycles, status 00.
- Load, size=3, stride 8; CTRL returns 01 twice then 11 -> SRAM writes at base, +8, +16 of PIM_R data; no STREAM before bit1.
- Grant dropped 2 cycles mid-stream, size=5 -> no strobes during drop, 5 writes in order, no lost or duplicate word.
- Abort during STREAM after 2 writes -> 1 DONE pulse, status 11, no further strobes.
- POLL_TIMEOUT=8, ctrl never ready -> done after 8 granted samples, status 10.
- funct3=000 and size=0 -> done 1 cycle after accept, status 01, no bus request.
